// File: rtl/riscv_pkg.sv
// riscv_pkg: shared memory-stage types and constants.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REGADDR_W = 5;
  localparam logic [3:0] MEM_TIMEOUT = 4'd15;
  typedef enum logic {IDLE, WAIT} memstate_t;
  typedef struct packed {
    logic                 regwrt;
    logic                 resultctrl;
    logic [REGADDR_W-1:0] rd;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      alu;
    logic [XLEN-1:0]      rdata;
  } mw_t;
endpackage

// File: rtl/memory_cycle_if.sv
// memory_cycle_if: data-memory request/ready handshake bus.
interface memory_cycle_if
  import riscv_pkg::*;
();
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ready, dmem_rdata);
  modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ready, dmem_rdata);
endinterface

// File: rtl/memory_cycle_mw_reg.sv
// mw_reg: M/W pipeline register; bubble clears the write-enables and holds the data fields.
module mw_reg
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bubble,
  input  mw_t  d,
  output mw_t  q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (bubble) begin
      q.regwrt     <= 1'b0;
      q.resultctrl <= 1'b0;
    end
    else q <= d;
endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: memory stage with data-memory handshake FSM, M/W register and result mux.
// Defining MEM_TIMEOUT_EN adds a WAIT-cycle timeout and the sticky merr_M output.
module memory_cycle
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regwrt_M,
  input  logic                 memwrite_M,
  input  logic                 resultctrl_M,
  input  logic [REGADDR_W-1:0] RD_M,
  input  logic [XLEN-1:0]      PC_1DEM,
  input  logic [XLEN-1:0]      ALUresult_M,
  input  logic [XLEN-1:0]      writedata_M,
  memory_cycle_if.master       dmem,
  output logic                 regwrt_W,
  output logic                 resultctrl_W,
  output logic [REGADDR_W-1:0] RD_W,
  output logic [XLEN-1:0]      PC_1W,
  output logic [XLEN-1:0]      ALUresult_W,
  output logic [XLEN-1:0]      readdata_W,
  output logic [XLEN-1:0]      ResultW,
  output logic                 stall_M
`ifdef MEM_TIMEOUT_EN
  , output logic               merr_M
`endif
);
  memstate_t r_state, w_next;
  logic w_acc, w_busy, w_tmo;
  mw_t  w_d, w_q;
  assign w_acc = memwrite_M | resultctrl_M;
  assign w_busy = r_state == WAIT || w_acc;
  assign dmem.dmem_req = rst && w_busy;
  assign dmem.dmem_we = dmem.dmem_req && memwrite_M;
  assign dmem.dmem_addr = ALUresult_M;
  assign dmem.dmem_wdata = writedata_M;
  assign stall_M = dmem.dmem_req && !dmem.dmem_ready && !w_tmo;
  always_ff @(posedge clk)
    r_state <= !rst ? IDLE : w_next;
  always_comb
    w_next = stall_M ? WAIT : IDLE;
`ifdef MEM_TIMEOUT_EN
  logic [3:0] r_cnt;
  logic       r_merr;
  assign w_tmo = r_state == WAIT && !dmem.dmem_ready && r_cnt == MEM_TIMEOUT;
  always_ff @(posedge clk)
    if (!rst) begin
      r_cnt  <= 4'd0;
      r_merr <= 1'b0;
    end
    else begin
      r_cnt  <= (r_state == WAIT && w_next == WAIT) ? r_cnt + 4'd1 : 4'd0;
      r_merr <= r_merr | w_tmo;
    end
  assign merr_M = r_merr;
`else
  assign w_tmo = 1'b0;
`endif
  // stores never write the register file; non-loads capture zero read data
  assign w_d = '{regwrt: regwrt_M & ~memwrite_M, resultctrl: resultctrl_M, rd: RD_M,
                 pc: PC_1DEM, alu: ALUresult_M,
                 rdata: resultctrl_M ? dmem.dmem_rdata : '0};
  mw_reg u_mw_reg (
    .clk    (clk),
    .rst    (rst),
    .bubble (stall_M | w_tmo),
    .d      (w_d),
    .q      (w_q)
  );
  assign regwrt_W = w_q.regwrt;
  assign resultctrl_W = w_q.resultctrl;
  assign RD_W = w_q.rd;
  assign PC_1W = w_q.pc;
  assign ALUresult_W = w_q.alu;
  assign readdata_W = w_q.rdata;
  assign ResultW = w_q.resultctrl ? w_q.rdata : w_q.alu;
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: table vectors, directed stall/reset/timeout sequences and randomized transactions.
module tb_memory_cycle;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic        regwrt_M, memwrite_M, resultctrl_M;
  logic [4:0]  RD_M;
  logic [31:0] PC_1DEM, ALUresult_M, writedata_M;
  logic        regwrt_W, resultctrl_W, stall_M;
  logic [4:0]  RD_W;
  logic [31:0] PC_1W, ALUresult_W, readdata_W, ResultW;
`ifdef MEM_TIMEOUT_EN
  logic        merr_M;
`endif
  memory_cycle_if dmem();
  memory_cycle dut (
    .clk          (clk),
    .rst          (rst),
    .regwrt_M     (regwrt_M),
    .memwrite_M   (memwrite_M),
    .resultctrl_M (resultctrl_M),
    .RD_M         (RD_M),
    .PC_1DEM      (PC_1DEM),
    .ALUresult_M  (ALUresult_M),
    .writedata_M  (writedata_M),
    .dmem         (dmem),
    .regwrt_W     (regwrt_W),
    .resultctrl_W (resultctrl_W),
    .RD_W         (RD_W),
    .PC_1W        (PC_1W),
    .ALUresult_W  (ALUresult_W),
    .readdata_W   (readdata_W),
    .ResultW      (ResultW),
    .stall_M      (stall_M)
`ifdef MEM_TIMEOUT_EN
    , .merr_M     (merr_M)
`endif
  );
  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic rw, input logic mw, input logic rc, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd);
    regwrt_M = rw;
    memwrite_M = mw;
    resultctrl_M = rc;
    RD_M = rd;
    PC_1DEM = pc;
    ALUresult_M = alu;
    writedata_M = wd;
  endtask
  typedef struct {
    logic rw, mw, rc, rdy;
    logic [4:0] rd;
    logic [31:0] alu, wd, rdata;
    logic e_req, e_we, e_wrw, e_wrc;
    logic [31:0] e_res;
  } vec_t;
  vec_t vt[6];
  int kind, lat, stalls;
  bit bub_ok;
  logic [31:0] last_rdata;
  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  32'h10,        32'h0,    32'h55,        1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  32'hABCD,      32'h99,   32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hABCD};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'h100,       32'h0,    32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  32'h200,       32'h1234, 32'h77,        1'b1, 1'b1, 1'b0, 1'b0, 32'h200};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h7,         32'h0,    32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h7};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'h0,    32'h1357_9BDF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF};
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h4, 32'h40, 32'h0);
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'h0;
    step();
    step();
    chk1("rst_req", dmem.dmem_req, 1'b0);
    chk1("rst_stall", stall_M, 1'b0);
    chk1("rst_regwrt_W", regwrt_W, 1'b0);
    chk("rst_RD_W", 32'(RD_W), 32'h0);
    chk("rst_ResultW", ResultW, 32'h0);
    chk("rst_PC_1W", PC_1W, 32'h0);
`ifdef MEM_TIMEOUT_EN
    chk1("rst_merr", merr_M, 1'b0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].rw, vt[i].mw, vt[i].rc, vt[i].rd, 32'h1000 + 32'(4 * i), vt[i].alu, vt[i].wd);
      dmem.dmem_ready = vt[i].rdy;
      dmem.dmem_rdata = vt[i].rdata;
      #1;
      chk1("vec_req", dmem.dmem_req, vt[i].e_req);
      chk1("vec_stall", stall_M, 1'b0);
      if (vt[i].e_req) begin
        chk1("vec_we", dmem.dmem_we, vt[i].e_we);
        chk("vec_addr", dmem.dmem_addr, vt[i].alu);
      end
      if (vt[i].e_we) chk("vec_wdata", dmem.dmem_wdata, vt[i].wd);
      step();
      chk1("vec_regwrt_W", regwrt_W, vt[i].e_wrw);
      chk1("vec_resultctrl_W", resultctrl_W, vt[i].e_wrc);
      chk("vec_RD_W", 32'(RD_W), 32'(vt[i].rd));
      chk("vec_PC_1W", PC_1W, 32'h1000 + 32'(4 * i));
      chk("vec_ResultW", ResultW, vt[i].e_res);
      chk("vec_readdata_W", readdata_W, vt[i].rc ? vt[i].rdata : 32'h0);
    end
    // store stalled three cycles behind an ALU op that already wrote W
    drive(1'b1, 1'b0, 1'b0, 5'd6, 32'h2000, 32'h60, 32'h0);
    dmem.dmem_ready = 1'b0;
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h2004, 32'h200, 32'h1234);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("st_stall", stall_M, 1'b1);
      chk1("st_req", dmem.dmem_req, 1'b1);
      chk1("st_we", dmem.dmem_we, 1'b1);
      chk("st_addr", dmem.dmem_addr, 32'h200);
      chk("st_wdata", dmem.dmem_wdata, 32'h1234);
      step();
      chk1("st_bubble_regwrt", regwrt_W, 1'b0);
      chk("st_bubble_hold_RD", 32'(RD_W), 32'd6);
    end
    dmem.dmem_ready = 1'b1;
    #1;
    chk1("st_done_stall", stall_M, 1'b0);
    step();
    chk1("st_regwrt_W", regwrt_W, 1'b0);
    chk("st_ALUresult_W", ALUresult_W, 32'h200);
    chk("st_RD_W", 32'(RD_W), 32'd4);
    // load waiting two cycles followed immediately by an ALU op
    drive(1'b1, 1'b0, 1'b1, 5'd10, 32'h3000, 32'h300, 32'h0);
    dmem.dmem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk1("ld_stall", stall_M, 1'b1);
      step();
      chk1("ld_bubble_regwrt", regwrt_W, 1'b0);
    end
    dmem.dmem_ready = 1'b1;
    dmem.dmem_rdata = 32'hCAFE_0001;
    #1;
    chk1("ld_done_stall", stall_M, 1'b0);
    step();
    chk("ld_RD_W", 32'(RD_W), 32'd10);
    chk1("ld_regwrt_W", regwrt_W, 1'b1);
    chk("ld_ResultW", ResultW, 32'hCAFE_0001);
    drive(1'b1, 1'b0, 1'b0, 5'd11, 32'h3004, 32'h44, 32'h0);
    dmem.dmem_ready = 1'b0;
    #1;
    chk1("alu_after_ld_stall", stall_M, 1'b0);
    step();
    chk("alu_after_ld_RD_W", 32'(RD_W), 32'd11);
    chk("alu_after_ld_ResultW", ResultW, 32'h44);
    chk1("alu_after_ld_regwrt", regwrt_W, 1'b1);
    // reset while waiting abandons the access
    drive(1'b1, 1'b0, 1'b1, 5'd12, 32'h4000, 32'h400, 32'h0);
    step();
    chk1("rw_wait_stall", stall_M, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rw_rst_req", dmem.dmem_req, 1'b0);
    chk1("rw_rst_stall", stall_M, 1'b0);
    step();
    chk1("rw_regwrt_W", regwrt_W, 1'b0);
    chk("rw_RD_W", 32'(RD_W), 32'h0);
    chk("rw_PC_1W", PC_1W, 32'h0);
    chk("rw_ALUresult_W", ALUresult_W, 32'h0);
    chk("rw_readdata_W", readdata_W, 32'h0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd13, 32'h4004, 32'h13, 32'h0);
    dmem.dmem_ready = 1'b1;
    dmem.dmem_rdata = 32'hBAD0_BAD0;
    #1;
    chk1("late_rdy_req", dmem.dmem_req, 1'b0);
    chk1("late_rdy_stall", stall_M, 1'b0);
    step();
    chk("late_rdy_RD_W", 32'(RD_W), 32'd13);
    chk("late_rdy_readdata_W", readdata_W, 32'h0);
    chk("late_rdy_ResultW", ResultW, 32'h13);
`ifdef MEM_TIMEOUT_EN
    drive(1'b1, 1'b0, 1'b1, 5'd14, 32'h5000, 32'h500, 32'h0);
    dmem.dmem_ready = 1'b0;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall_M) break;
      stalls++;
      step();
    end
    chk("tmo_stall_cycles", 32'(stalls), 32'd16);
    chk1("tmo_req_held", dmem.dmem_req, 1'b1);
    step();
    chk1("tmo_merr", merr_M, 1'b1);
    chk1("tmo_bubble_regwrt", regwrt_W, 1'b0);
    chk1("tmo_bubble_rc", resultctrl_W, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    step();
    step();
    chk1("tmo_merr_sticky", merr_M, 1'b1);
    rst = 1'b0;
    step();
    chk1("tmo_merr_cleared", merr_M, 1'b0);
    rst = 1'b1;
`endif
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 2);
      lat = (kind == 0) ? 0 : $urandom_range(0, 3);
      drive(1'($urandom_range(0, 1)), kind == 2, kind == 1, 5'($urandom), $urandom, $urandom, $urandom);
      stalls = 0;
      bub_ok = 1'b1;
      for (int c = 0; c <= lat; c++) begin
        dmem.dmem_ready = (kind == 0) ? 1'($urandom_range(0, 1)) : (c == lat);
        dmem.dmem_rdata = $urandom;
        last_rdata = dmem.dmem_rdata;
        #1;
        if (stall_M) stalls++;
        if (c == 0) chk1("rnd_req", dmem.dmem_req, kind != 0);
        step();
        if (c < lat && (regwrt_W || resultctrl_W)) bub_ok = 1'b0;
      end
      chk("rnd_stalls", 32'(stalls), 32'(lat));
      chk1("rnd_bubble", bub_ok, 1'b1);
      chk1("rnd_regwrt_W", regwrt_W, regwrt_M && kind != 2);
      chk("rnd_RD_W", 32'(RD_W), 32'(RD_M));
      chk("rnd_ResultW", ResultW, kind == 1 ? last_rdata : ALUresult_M);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
